// File: rtl/param_mod_counter.sv
// Up/down modulo-N counter with clock-enable prescaler, load, manual set buttons and carry/borrow pulses.
// Optional auto-repeat of held set buttons: define PARAM_MOD_COUNTER_AUTOREPEAT_EN.
module param_mod_counter #(
  parameter int unsigned WIDTH         = 3,
  parameter int unsigned MODULUS       = 6,
  parameter int unsigned TICK_DIV      = 4,
  parameter int unsigned INIT          = 0,
  parameter int unsigned HOLD_CYCLES   = 8,
  parameter int unsigned REPEAT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             count_up,
  input  logic             count_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic             borrow_out,
  output logic             tc
);

  localparam int unsigned XW = WIDTH + 1;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [XW-1:0] MOD_MAX = XW'(MODULUS - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_presc;
  logic             r_up_d;
  logic             r_dn_d;
  logic             r_carry;
  logic             r_borrow;

  logic             w_up_press;
  logic             w_dn_press;
  logic             w_rep_up;
  logic             w_rep_dn;
  logic             w_step_up;
  logic             w_step_dn;
  logic             w_manual;
  logic             w_tick;
  logic [XW-1:0]    w_cnt_x;
  logic [XW-1:0]    w_load_x;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  logic [WIDTH-1:0] w_load_sat;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_carry_nxt;
  logic             w_borrow_nxt;

  assign w_up_press = count_up & ~r_up_d;
  assign w_dn_press = count_down & ~r_dn_d;
  assign w_tick     = en & (r_presc == PRE_MAX);

  // Wrap arithmetic one bit wider so MODULUS == 2**WIDTH still wraps correctly.
  assign w_cnt_x    = {1'b0, r_count};
  assign w_load_x   = {1'b0, load_val};
  assign w_inc      = (w_cnt_x == MOD_MAX) ? '0 : WIDTH'(w_cnt_x + XW'(1));
  assign w_dec      = (w_cnt_x == '0) ? WIDTH'(MOD_MAX) : WIDTH'(w_cnt_x - XW'(1));
  assign w_load_sat = (w_load_x > MOD_MAX) ? WIDTH'(MOD_MAX) : load_val;

`ifdef PARAM_MOD_COUNTER_AUTOREPEAT_EN
  localparam int unsigned HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HW   = $clog2(HMAX + 1);

  logic [HW-1:0] r_hold;
  logic          r_rep_phase;
  logic          w_single;
  logic          w_single_press;
  logic          w_held;
  logic          w_rep_fire;
  logic [HW-1:0] w_target;

  assign w_single       = count_up ^ count_down;
  assign w_single_press = (w_up_press & ~count_down) | (w_dn_press & ~count_up);
  assign w_held         = (count_up & ~count_down & r_up_d) | (count_down & ~count_up & r_dn_d);
  assign w_target       = r_rep_phase ? HW'(REPEAT_CYCLES) : HW'(HOLD_CYCLES);
  assign w_rep_fire     = w_held & (r_hold != '0) & (r_hold == w_target);
  assign w_rep_up       = w_rep_fire & count_up;
  assign w_rep_dn       = w_rep_fire & count_down;

  // r_hold counts cycles since the last step; zero means no hold in progress.
  always_ff @(posedge clk) begin
    if (!reset || load || !w_single) begin
      r_hold      <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_single_press) begin
      r_hold      <= HW'(1);
      r_rep_phase <= 1'b0;
    end else if (w_rep_fire) begin
      r_hold      <= HW'(1);
      r_rep_phase <= 1'b1;
    end else if (r_hold != '0) begin
      r_hold      <= r_hold + HW'(1);
    end
  end
`else
  assign w_rep_up = 1'b0;
  assign w_rep_dn = 1'b0;
`endif

  assign w_step_up = (w_up_press & ~w_dn_press) | w_rep_up;
  assign w_step_dn = (w_dn_press & ~w_up_press) | w_rep_dn;
  assign w_manual  = w_up_press | w_dn_press | w_rep_up | w_rep_dn;

  // Priority: load, then manual step (any press consumes the cycle), then tick.
  always_comb begin
    w_cnt_nxt    = r_count;
    w_carry_nxt  = 1'b0;
    w_borrow_nxt = 1'b0;
    if (load) begin
      w_cnt_nxt = w_load_sat;
    end else if (w_manual) begin
      if (w_step_up && !w_step_dn) begin
        w_cnt_nxt = w_inc;
      end else if (w_step_dn && !w_step_up) begin
        w_cnt_nxt = w_dec;
      end
    end else if (w_tick) begin
      if (dir) begin
        w_cnt_nxt    = w_dec;
        w_borrow_nxt = (w_cnt_x == '0);
      end else begin
        w_cnt_nxt    = w_inc;
        w_carry_nxt  = (w_cnt_x == MOD_MAX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count  <= WIDTH'(INIT);
      r_presc  <= '0;
      r_up_d   <= 1'b0;
      r_dn_d   <= 1'b0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_count  <= w_cnt_nxt;
      r_up_d   <= count_up;
      r_dn_d   <= count_down;
      r_carry  <= w_carry_nxt;
      r_borrow <= w_borrow_nxt;
      if (load) begin
        r_presc <= '0;
      end else if (en) begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
      end
    end
  end

  assign count      = r_count;
  assign carry_out  = r_carry;
  assign borrow_out = r_borrow;
  assign tc         = dir ? (w_cnt_x == '0) : (w_cnt_x == MOD_MAX);

endmodule

// File: tb/tb_param_mod_counter.sv
// Directed bench for param_mod_counter: main instance (mod 6), INIT=4 reset check, and a full-range mod-8 instance.
module tb_param_mod_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       dir;
  logic       count_up;
  logic       count_down;
  logic       load;
  logic [2:0] load_val;

  logic [2:0] count,  count4,  count8;
  logic       carry,  carry4,  carry8;
  logic       borrow, borrow4, borrow8;
  logic       tc,     tc4,     tc8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  param_mod_counter #(.WIDTH(3), .MODULUS(6), .TICK_DIV(4), .INIT(0)) u_dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .count_up(count_up),
    .count_down(count_down), .load(load), .load_val(load_val),
    .count(count), .carry_out(carry), .borrow_out(borrow), .tc(tc));

  param_mod_counter #(.WIDTH(3), .MODULUS(6), .TICK_DIV(4), .INIT(4)) u_dut4 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .count_up(count_up),
    .count_down(count_down), .load(load), .load_val(load_val),
    .count(count4), .carry_out(carry4), .borrow_out(borrow4), .tc(tc4));

  param_mod_counter #(.WIDTH(3), .MODULUS(8), .TICK_DIV(1), .INIT(7)) u_dut8 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .count_up(count_up),
    .count_down(count_down), .load(load), .load_val(load_val),
    .count(count8), .carry_out(carry8), .borrow_out(borrow8), .tc(tc8));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int exp_cnt, input int exp_carry, input int exp_borrow);
    chk({tag, ".count"},  int'(count),  exp_cnt);
    chk({tag, ".carry"},  int'(carry),  exp_carry);
    chk({tag, ".borrow"}, int'(borrow), exp_borrow);
  endtask

  initial begin
    int exp_c;
    reset = 1'b0; en = 1'b0; dir = 1'b0; count_up = 1'b0; count_down = 1'b0;
    load = 1'b0; load_val = 3'd0;

    steps(2);
    chk_cnt("reset", 0, 0, 0);
    chk("reset.init4", int'(count4), 4);
    chk("reset.init7", int'(count8), 7);

    // Count up: tick every 4th cycle, carry after 5->0
    reset = 1'b1; en = 1'b1; dir = 1'b0;
    step();
    chk("mod8.wrap.count", int'(count8), 0);
    chk("mod8.wrap.carry", int'(carry8), 1);
    chk("up.c1", int'(count), 0);
    for (int i = 2; i <= 24; i++) begin
      step();
      exp_c = (i / 4) % 6;
      chk($sformatf("up.count%0d", i), int'(count), exp_c);
      chk($sformatf("up.carry%0d", i), int'(carry), (i == 24) ? 1 : 0);
      chk($sformatf("up.tc%0d", i), int'(tc), (exp_c == 5) ? 1 : 0);
    end

    // Count down: 0 -> 5 with borrow
    dir = 1'b1;
    #1;
    chk("down.tc0", int'(tc), 1);
    steps(3);
    chk_cnt("down.pre", 0, 0, 0);
    step();
    chk_cnt("down.wrap", 5, 0, 1);
    step();
    chk_cnt("down.after", 5, 0, 0);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_cnt($sformatf("frozen%0d", i), 5, 0, 0);
    end

    // Manual set with en=0
    dir = 1'b0;
    load = 1'b1; load_val = 3'd2; step(); load = 1'b0;
    chk("load2", int'(count), 2);
    count_up = 1'b1;
    step();
    chk("hold.first", int'(count), 3);
    steps(9);
    chk("hold.single", int'(count), 3);
    count_up = 1'b0; step();
    load = 1'b1; load_val = 3'd5; step(); load = 1'b0;
    count_up = 1'b1; step();
    chk_cnt("manual.wrap", 0, 0, 0);
    count_up = 1'b0; step();
    count_up = 1'b1; count_down = 1'b1; step();
    chk_cnt("both", 0, 0, 0);
    count_up = 1'b0; count_down = 1'b0; step();

    // Load saturation and priority over tick
    load = 1'b1; load_val = 3'd7; step(); load = 1'b0;
    chk("load.sat", int'(count), 5);
    en = 1'b1;
    steps(3);
    chk("pre.tick", int'(count), 5);
    chk("pre.tick.tc", int'(tc), 1);
    load = 1'b1; load_val = 3'd3; step(); load = 1'b0;
    chk_cnt("load.vs.tick", 3, 0, 0);
    steps(3);
    chk("presc.cleared", int'(count), 3);
    step();
    chk("tick.after.load", int'(count), 4);
    steps(3);
    count_up = 1'b1; step();
    chk_cnt("press.vs.tick", 5, 0, 0);
    steps(3);
    chk("presc.kept", int'(count), 5);
    step();
    chk_cnt("tick.wrap", 0, 1, 0);
    count_up = 1'b0; en = 1'b0; step();
    chk("carry.one", int'(carry), 0);

    // Reset from non-trivial state
    load = 1'b1; load_val = 3'd3; step(); load = 1'b0;
    reset = 1'b0; steps(2);
    chk_cnt("reset2", 0, 0, 0);
    chk("reset2.init4", int'(count4), 4);
    reset = 1'b1; step();

`ifdef PARAM_MOD_COUNTER_AUTOREPEAT_EN
    count_up = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      step();
      exp_c = 1 + ((k >= 8) ? 1 : 0) + ((k >= 12) ? 1 : 0) + ((k >= 16) ? 1 : 0);
      chk($sformatf("rep.k%0d", k), int'(count), exp_c);
    end
    chk("rep.carry", int'(carry), 0);
    count_up = 1'b0; step();
    chk("rep.release", int'(count), 4);
    count_up = 1'b1; step();
    chk("rep.repress", int'(count), 5);
    count_up = 1'b0; step();
`else
    count_up = 1'b1;
    steps(17);
    chk("norep.hold", int'(count), 1);
    count_up = 1'b0; step();
    count_up = 1'b1; step();
    chk("norep.repress", int'(count), 2);
    count_up = 1'b0; step();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
